// File: rtl/intr_ctrl.sv
// Interrupt controller: 8 edge-detected lines, fault/syscall entry,
// priority select, vector generation and double-fault halt.
module intr_ctrl #(
    parameter int VEC_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_in,
    input  logic        fault_in,
    input  logic        syscall,
    input  logic        reti,
    input  logic        ack,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        irq_r,
    output logic        fault_r,
    output logic [15:0] vector,
    output logic [3:0]  cause,
    output logic        in_service,
    output logic        halt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mask;
    logic [7:0]  pending;
    logic [7:0]  irq_prev;
    logic [15:0] vbase;
    logic        ie;

    logic [3:0]  cause_nxt;
    logic        fault_nxt;
    logic        take_ack;
    logic [7:0]  rise;
    logic [7:0]  w1c;
    logic [7:0]  ack_clr;
    logic [7:0]  pend_w1c;
    logic [7:0]  eligible;
    logic        any_elig;
    logic [2:0]  sel;

    // A halted core no longer latches new requests.
    assign rise     = (state == HALTED) ? 8'h00 : (irq_in & ~irq_prev);
    assign w1c      = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata[7:0] : 8'h00;
    assign pend_w1c = (pending & ~w1c) | rise;
    assign eligible = pending & mask;
    assign any_elig = |eligible;
    assign ack_clr  = take_ack ? (8'h01 << sel) : 8'h00;

    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        fault_nxt = 1'b0;
        take_ack  = 1'b0;
        unique case (state)
            IDLE, PENDING: begin
                if (fault_in) begin
                    state_nxt = SERVICE;
                    cause_nxt = 4'd8;
                    fault_nxt = 1'b1;
                end else if (syscall) begin
                    state_nxt = SERVICE;
                    cause_nxt = 4'd9;
                    fault_nxt = 1'b1;
                end else if (state == PENDING && ack && any_elig) begin
                    state_nxt = SERVICE;
                    cause_nxt = {1'b0, sel};
                    take_ack  = 1'b1;
                end else if (state == IDLE && ie && any_elig) begin
                    state_nxt = PENDING;
                end else if (state == PENDING &&
                             (!ie || (pend_w1c & mask) == 8'h00)) begin
                    // Withdraw as soon as the request is cleared at this edge.
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (fault_in && reti) begin
                    cause_nxt = 4'd8;
                    fault_nxt = 1'b1;
                end else if (fault_in) begin
                    state_nxt = HALTED;
                end else if (reti) begin
                    state_nxt = IDLE;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= 8'h00;
            vbase    <= 16'h0000;
            ie       <= 1'b0;
            pending  <= 8'h00;
            irq_prev <= 8'h00;
            cause    <= 4'd0;
            fault_r  <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~(w1c | ack_clr)) | rise;
            cause    <= cause_nxt;
            fault_r  <= fault_nxt;
            if (cfg_we) begin
                unique case (cfg_addr)
                    2'd0: mask  <= cfg_wdata[7:0];
                    2'd1: vbase <= cfg_wdata;
                    2'd2: ie    <= cfg_wdata[0];
                    2'd3: ;
                endcase
            end
        end
    end

    always_comb begin
        irq_r      = (state == PENDING);
        in_service = (state == SERVICE);
        halt       = (state == HALTED);
        vector     = vbase + (16'(cause) * 16'(VEC_STRIDE));
        cfg_rdata  = 16'h0000;
        unique case (cfg_addr)
            2'd0: cfg_rdata = {8'h00, mask};
            2'd1: cfg_rdata = vbase;
            2'd2: cfg_rdata = {15'h0000, ie};
            2'd3: cfg_rdata = {state, 2'b00, cause, pending};
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed plus random bench for intr_ctrl against a behavioural
// model of the controller rules.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = 8'h00;
    logic        fault_in = 1'b0;
    logic        syscall = 1'b0;
    logic        reti = 1'b0;
    logic        ack = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = 16'h0000;
    logic [15:0] cfg_rdata;
    logic        irq_r;
    logic        fault_r;
    logic [15:0] vector;
    logic [3:0]  cause;
    logic        in_service;
    logic        halt;

    int total = 0;
    int bad = 0;

    // model state: 0 idle, 1 pending, 2 service, 3 halted
    int         m_state;
    logic [7:0] m_mask, m_pend, m_prev;
    logic [15:0] m_vbase;
    logic       m_ie;
    int         m_cause;
    logic       m_fr;

    intr_ctrl dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .fault_in(fault_in),
        .syscall(syscall), .reti(reti), .ack(ack), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .irq_r(irq_r), .fault_r(fault_r), .vector(vector), .cause(cause),
        .in_service(in_service), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input int a);
        case (a)
            0: return {8'h00, m_mask};
            1: return m_vbase;
            2: return {15'h0, m_ie};
            default: return {2'(m_state), 2'b00, 4'(m_cause), m_pend};
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] rise, clr, elig;
        int sel;
        if (reset) begin
            m_state = 0; m_mask = 0; m_vbase = 0; m_ie = 0;
            m_pend = 0; m_prev = 0; m_cause = 0; m_fr = 0;
            return;
        end
        rise = (m_state == 3) ? 8'h00 : (irq_in & ~m_prev);
        clr  = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata[7:0] : 8'h00;
        elig = m_pend & m_mask;
        sel = -1;
        for (int i = 7; i >= 0; i--) if (elig[i]) sel = i;
        m_fr = 0;
        if (m_state == 0 || m_state == 1) begin
            if (fault_in) begin m_state = 2; m_cause = 8; m_fr = 1; end
            else if (syscall) begin m_state = 2; m_cause = 9; m_fr = 1; end
            else if (m_state == 1 && ack && sel >= 0) begin
                m_state = 2; m_cause = sel; clr[sel] = 1'b1;
            end else if (m_state == 0) begin
                if (m_ie && sel >= 0) m_state = 1;
            end else if (!m_ie || (((m_pend & ~clr) | rise) & m_mask) == 0)
                m_state = 0;
        end else if (m_state == 2) begin
            if (fault_in && reti) begin m_cause = 8; m_fr = 1; end
            else if (fault_in) m_state = 3;
            else if (reti) m_state = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        m_prev = irq_in;
        if (cfg_we) begin
            if (cfg_addr == 0) m_mask = cfg_wdata[7:0];
            if (cfg_addr == 1) m_vbase = cfg_wdata;
            if (cfg_addr == 2) m_ie = cfg_wdata[0];
        end
    endtask

    task automatic check_all();
        logic [1:0] keep;
        int v;
        v = (int'(m_vbase) + m_cause * 4) & 16'hFFFF;
        chk("irq_r", 16'(irq_r), 16'(m_state == 1));
        chk("in_service", 16'(in_service), 16'(m_state == 2));
        chk("halt", 16'(halt), 16'(m_state == 3));
        chk("fault_r", 16'(fault_r), 16'(m_fr));
        chk("cause", 16'(cause), 16'(m_cause));
        chk("vector", vector, 16'(v));
        keep = cfg_addr;
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk("cfg_rdata", cfg_rdata, model_rd(a));
        end
        cfg_addr = keep;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        fault_in = 0; syscall = 0; reti = 0; ack = 0; cfg_we = 0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        tick();
    endtask

    task automatic read_status(output logic [15:0] s);
        cfg_addr = 2'd3;
        #1;
        s = cfg_rdata;
    endtask

    initial begin
        logic [15:0] st;
        reset = 1;
        tick();
        reset = 0;

        cfg_write(2'd0, 16'h00FF);
        cfg_write(2'd1, 16'h0100);
        cfg_write(2'd2, 16'h0001);
        irq_in = 8'h08; tick();
        irq_in = 8'h0A; tick();
        chk("r30_irq_r", 16'(irq_r), 16'h1);
        ack = 1; tick();
        read_status(st);
        chk("r30_cause", 16'(cause), 16'h1);
        chk("r30_vector", vector, 16'h0104);
        chk("r30_pend", 16'(st[7:0]), 16'h08);
        chk("r30_insvc", 16'(in_service), 16'h1);
        reti = 1; irq_in = 8'h00;
        cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 16'h00FF;
        tick();

        irq_in = 8'h04; tick(); tick();
        chk("r31_irq_r", 16'(irq_r), 16'h1);
        cfg_write(2'd3, 16'h0004);
        read_status(st);
        chk("r31_state", 16'(st[15:14]), 16'h0);
        chk("r31_irq_r0", 16'(irq_r), 16'h0);
        irq_in = 8'h00; tick();

        cfg_write(2'd2, 16'h0000);
        fault_in = 1; tick();
        chk("r32_cause", 16'(cause), 16'h8);
        chk("r32_vector", vector, 16'h0120);
        chk("r32_fault_r", 16'(fault_r), 16'h1);
        tick();
        chk("r32_fault_r0", 16'(fault_r), 16'h0);
        reti = 1; tick();
        chk("r32_idle", 16'(in_service), 16'h0);

        cfg_write(2'd2, 16'h0001);
        irq_in = 8'h20; tick(); tick();
        fault_in = 1; syscall = 1; ack = 1; tick();
        read_status(st);
        chk("r33_cause", 16'(cause), 16'h8);
        chk("r33_pend", 16'(st[5]), 16'h1);
        reti = 1; tick();
        tick();
        chk("r33_irq_r", 16'(irq_r), 16'h1);
        ack = 1; tick();
        chk("r33_cause5", 16'(cause), 16'h5);
        reti = 1; irq_in = 8'h00; tick();

        fault_in = 1; tick();
        fault_in = 1; tick();
        chk("r34_halt", 16'(halt), 16'h1);
        reti = 1; tick();
        chk("r34_halt_hold", 16'(halt), 16'h1);
        reset = 1; tick(); reset = 0;
        chk("r34_rst_halt", 16'(halt), 16'h0);
        chk("r34_rst_vec", vector, 16'h0000);

        cfg_write(2'd1, 16'hFFF8);
        syscall = 1; tick();
        chk("r35_vector", vector, 16'h001C);
        reti = 1; tick();

        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            fault_in = ($urandom_range(0, 79) == 0);
            syscall  = ($urandom_range(0, 29) == 0);
            reti     = ($urandom_range(0, 3) == 0);
            ack      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                irq_in = irq_in ^ (8'($urandom) & 8'($urandom));
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = 16'($urandom);
            if (cfg_addr == 2'd2 && $urandom_range(0, 3) != 0)
                cfg_wdata[0] = 1'b1;
            tick();
        end
        reset = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
